// File: rtl/sha3_256_absorb_feeder.sv
// sha3_256_absorb_feeder: packs a byte stream into pad10*1-padded SHA3-256 rate blocks.
module sha3_256_absorb_feeder #(
  parameter int          RATE_BYTES = 136,
  parameter logic [7:0]  DOMAIN_PAD = 8'h06,
  parameter logic [7:0]  FINAL_PAD  = 8'h80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_last,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    proto_err
);
  localparam int W  = 8 * RATE_BYTES;
  localparam int CW = $clog2(RATE_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_BYTES - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic [CW+2:0]   pos, pos_n;
  logic            at_end;

  assign pos       = {cnt_q, 3'b000};
  assign pos_n     = pos + (CW+3)'(8);
  assign at_end    = cnt_q == LAST_IDX;
  assign in_ready  = state_q == FILL;
  assign blk_valid = state_q == EMIT;
  assign blk_data  = buf_q;
  assign blk_last  = last_q;
  assign proto_err = err_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (state_q == FILL && in_valid) begin
      if (in_keep) buf_d[pos +: 8] = in_data;
      else if (in_last) buf_d[pos +: 8] = buf_q[pos +: 8] ^ DOMAIN_PAD;
      if (in_keep && !in_last && !at_end) cnt_d = cnt_q + CW'(1);
      else if (!in_keep && !in_last) err_d = 1'b1;
      else begin
        state_d = EMIT;
        last_d  = in_last && !(in_keep && at_end);
        pend_d  = in_keep && in_last && at_end;
        // A last data byte in the final slot leaves no room: padding goes in an extra block.
        if (in_keep && in_last && !at_end) buf_d[pos_n +: 8] = DOMAIN_PAD;
        if (last_d) buf_d[W-1 -: 8] = buf_d[W-1 -: 8] | FINAL_PAD;
      end
    end else if (state_q == EMIT && blk_ready) begin
      buf_d  = '0;
      pend_d = 1'b0;
      if (pend_q) begin
        buf_d[7:0]      = DOMAIN_PAD;
        buf_d[W-1 -: 8] = FINAL_PAD;
        last_d          = 1'b1;
      end else begin
        cnt_d   = '0;
        last_d  = 1'b0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_sha3_256_absorb_feeder.sv
// tb_sha3_256_absorb_feeder: scoreboard bench for the SHA3-256 absorb feeder.
module tb_sha3_256_absorb_feeder;
  localparam int RB = 136;
  localparam int W  = 8 * RB;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_keep = 1'b0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] blk_data;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic         proto_err;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   stall_en = 1'b0;

  sha3_256_absorb_feeder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .blk_data(blk_data), .blk_last(blk_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_blk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      for (int k = 0; k < RB; k++)
        if (act[8*k +: 8] !== exp[8*k +: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", name, k, act[8*k +: 8], exp[8*k +: 8]);
          break;
        end
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [W-1:0] pat_block(input int s, input int n);
    logic [W-1:0] b = '0;
    for (int k = 0; k < n; k++) b[8*k +: 8] = pat(s + k);
    return b;
  endfunction

  task automatic push(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic k, input logic l);
    int w = 0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 300) begin @(negedge clk); w++; end
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pat(input int s, input int n, input logic last);
    for (int k = 0; k < n; k++) send(pat(s + k), 1'b1, last && (k == n - 1));
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin @(posedge clk); w++; end
    #1 chk("drain", sb.size(), 0);
  endtask

  task automatic send_abc(input bit bad);
    send(8'h61, 1'b1, 1'b0);
    if (bad) begin
      send(8'hee, 1'b0, 1'b0);
      chk("proto_err_set", {31'd0, proto_err}, 32'd1);
    end
    send(8'h62, 1'b1, 1'b0);
    chk("abc_not_yet_valid", {31'd0, blk_valid}, 32'd0);
    send(8'h63, 1'b1, 1'b1);
    chk("abc_latency", {31'd0, blk_valid}, 32'd1);
  endtask

  function automatic logic [W-1:0] abc_block();
    logic [W-1:0] b = '0;
    b[23:0]      = 24'h636261;
    b[31:24]     = 8'h06;
    b[W-1 -: 8]  = 8'h80;
    return b;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_blk_valid"}, {31'd0, blk_valid}, 32'd0);
    chk({tag, "_blk_last"}, {31'd0, blk_last}, 32'd0);
    chk({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
    chk_blk({tag, "_blk_data"}, blk_data, '0);
  endtask

  // blk_ready driver: holds off each newly presented block for a random stall
  initial begin
    bit hs;
    bit fresh = 1'b1;
    int stall = 0;
    forever begin
      @(negedge clk);
      hs = blk_valid && blk_ready;
      @(posedge clk); #1;
      if (hs || !blk_valid) fresh = 1'b1;
      if (blk_valid && fresh) begin
        stall = stall_en ? int'($urandom_range(1, 5)) : 0;
        fresh = 1'b0;
      end else if (stall > 0) stall--;
      blk_ready = (stall == 0);
    end
  end

  // monitor: compares every accepted block and checks hold-stability while stalled
  initial begin
    bit held = 1'b0;
    logic [W-1:0] prev_d;
    logic prev_l;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && blk_valid) begin
        chk("in_ready_in_emit", {31'd0, in_ready}, 32'd0);
        if (held) begin
          chk_blk("stable_data", blk_data, prev_d);
          chk("stable_last", {31'd0, blk_last}, {31'd0, prev_l});
        end
        if (blk_ready) begin
          if (sb.size() == 0) chk("unexpected_block", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk_blk("blk_data", blk_data, e.d);
            chk("blk_last", {31'd0, blk_last}, {31'd0, e.l});
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev_d = blk_data;
          prev_l = blk_last;
        end
      end else held = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] b;
    #2 chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    b = '0; b[7:0] = 8'h06; b[W-1 -: 8] = 8'h80;
    push(b, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    drain();

    push(abc_block(), 1'b1);
    send_abc(1'b0);
    drain();

    b = pat_block(0, 134); b[8*134 +: 8] = 8'h06; b[W-1 -: 8] = 8'h80;
    push(b, 1'b1);
    send_pat(0, 134, 1'b1);
    drain();

    b = pat_block(0, 135); b[W-1 -: 8] = 8'h86;
    push(b, 1'b1);
    send_pat(0, 135, 1'b1);
    drain();

    b = pat_block(5, 135); b[W-1 -: 8] = 8'h86;
    push(b, 1'b1);
    send_pat(5, 135, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    drain();

    push(pat_block(0, 136), 1'b0);
    b = '0; b[7:0] = 8'h06; b[W-1 -: 8] = 8'h80;
    push(b, 1'b1);
    send_pat(0, 136, 1'b1);
    drain();

    stall_en = 1'b1;
    push(pat_block(10, 136), 1'b0);
    push(pat_block(146, 136), 1'b0);
    b = pat_block(282, 18); b[8*18 +: 8] = 8'h06; b[W-1 -: 8] = 8'h80;
    push(b, 1'b1);
    send_pat(10, 290, 1'b1);
    drain();
    stall_en = 1'b0;

    send_pat(20, 50, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1'b0;
    push(abc_block(), 1'b1);
    send_abc(1'b0);
    drain();

    push(abc_block(), 1'b1);
    send_abc(1'b1);
    drain();
    chk("proto_err_sticky", {31'd0, proto_err}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("proto_err_cleared", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
